xc_aesmix_seq: RTL and testbench

Sequencer that applies AES MixColumns or InvMixColumns to a full 128-bit state by driving a single shared `xc_aesmix` unit one 32-bit column at a time. It sits between the crypto coprocessor's AES round control and the `xc_aesmix` instance. It flushes the unit before each operation, holds column operands until the unit signals completion, and collects the four results. It works with either the single-cycle (`FAST=1`) or the 4-cycle (`FAST=0`) build of the unit, with no configuration change.

---
 rtl/xc_aesmix_seq_if.sv | 46 ++++
 rtl/xc_aesmix_seq.sv | 215 +++++++++++++++++++++
 tb/tb_xc_aesmix_seq.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/xc_aesmix_seq_if.sv
// ---------------------------------------------------------------------------
// xc_aesmix_seq_if
// Bus between the MixColumns sequencer and one shared xc_aesmix unit.
//   master modport : sequencer side (drives flush/valid/operands).
//   slave modport  : xc_aesmix side (returns ready/result).
// Signals:
//   mix_flush      - flush the unit (clears any partial computation)
//   mix_flush_data - data presented with a flush (always zero here)
//   mix_valid      - operands valid
//   mix_enc        - 1 = MixColumns, 0 = InvMixColumns
//   mix_rs1/rs2    - 32-bit column operand (both carry the same word)
//   mix_ready      - result for the held operands is available
//   mix_result     - 32-bit mixed column
// ---------------------------------------------------------------------------
interface xc_aesmix_seq_if;
    logic        mix_flush;
    logic [31:0] mix_flush_data;
    logic        mix_valid;
    logic        mix_enc;
    logic [31:0] mix_rs1;
    logic [31:0] mix_rs2;
    logic        mix_ready;
    logic [31:0] mix_result;

    modport master (
        output mix_flush,
        output mix_flush_data,
        output mix_valid,
        output mix_enc,
        output mix_rs1,
        output mix_rs2,
        input  mix_ready,
        input  mix_result
    );

    modport slave (
        input  mix_flush,
        input  mix_flush_data,
        input  mix_valid,
        input  mix_enc,
        input  mix_rs1,
        input  mix_rs2,
        output mix_ready,
        output mix_result
    );
endinterface

// File: rtl/xc_aesmix_seq.sv
// ---------------------------------------------------------------------------
// xc_aesmix_seq
// Applies AES MixColumns / InvMixColumns to a full 128-bit state by feeding
// a shared xc_aesmix unit one 32-bit column at a time. The unit is flushed
// before every operation, each column is held until the unit reports ready,
// and the four results are published together with a one-cycle done pulse.
// Works unchanged with single-cycle or multi-cycle unit builds.
//
// Ports:
//   clock, reset   - clock, synchronous active-high reset
//   start          - begin an operation (sampled only when idle)
//   abort          - cancel the operation in progress
//   enc            - 1 = MixColumns, 0 = InvMixColumns (latched on start)
//   state_in       - input state, column c = state_in[32c+31:32c]
//   key_in         - round key (used only when XC_AESMIX_SEQ_ARK_EN)
//   busy           - high whenever not idle
//   done           - one-cycle pulse when state_out is updated
//   state_out      - result state, holds until the next done
//   mix            - master side of xc_aesmix_seq_if towards xc_aesmix
//
// Build option:
//   XC_AESMIX_SEQ_ARK_EN - XOR each captured column with the latched key
//                          column (fused MixColumns + AddRoundKey).
// ---------------------------------------------------------------------------
module xc_aesmix_seq (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic                   enc,
    input  logic [127:0]           state_in,
    input  logic [127:0]           key_in,
    output logic                   busy,
    output logic                   done,
    output logic [127:0]           state_out,
    xc_aesmix_seq_if.master        mix
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_FLUSH = 3'd1;
    localparam logic [2:0] ST_ISSUE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ABORT = 3'd4;

    // Extract column c of a 128-bit state.
    function automatic logic [31:0] col_word(input logic [127:0] s, input logic [1:0] c);
        logic [31:0] w;
        case (c)
            2'd0:    w = s[31:0];
            2'd1:    w = s[63:32];
            2'd2:    w = s[95:64];
            2'd3:    w = s[127:96];
            default: w = 32'h0000_0000;
        endcase
        return w;
    endfunction

    // Replace column c of a 128-bit state with word w.
    function automatic logic [127:0] put_word(input logic [127:0] s, input logic [1:0] c,
                                              input logic [31:0] w);
        logic [127:0] r;
        r = s;
        case (c)
            2'd0:    r[31:0]   = w;
            2'd1:    r[63:32]  = w;
            2'd2:    r[95:64]  = w;
            2'd3:    r[127:96] = w;
            default: r = s;
        endcase
        return r;
    endfunction

    logic [2:0]   r_state;
    logic [1:0]   r_col;
    logic [127:0] r_in;
    logic         r_enc;
    logic [127:0] r_buf;
    logic [127:0] r_state_out;
    logic         r_busy;
    logic         r_done;
    logic         r_mix_valid;
    logic         r_mix_flush;
    logic         r_mix_enc;
    logic [31:0]  r_mix_op;

    logic [2:0]   w_state_nxt;
    logic [1:0]   w_col_nxt;
    logic [127:0] w_in_nxt;
    logic         w_enc_nxt;
    logic [127:0] w_buf_nxt;
    logic [127:0] w_out_nxt;
    logic [31:0]  w_cap_word;

`ifdef XC_AESMIX_SEQ_ARK_EN
    logic [127:0] r_key;
    logic [127:0] w_key_nxt;
    assign w_cap_word = mix.mix_result ^ col_word(r_key, r_col);
`else
    // Key is not needed in the pure MixColumns build.
    logic w_key_unused;
    assign w_key_unused = ^key_in;
    assign w_cap_word   = mix.mix_result;
`endif

    // Next-state, column counter, operand latch and result collection.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_in_nxt    = r_in;
        w_enc_nxt   = r_enc;
        w_buf_nxt   = r_buf;
        w_out_nxt   = r_state_out;
`ifdef XC_AESMIX_SEQ_ARK_EN
        w_key_nxt   = r_key;
`endif
        case (r_state)
            ST_IDLE: begin
                if (start && !abort) begin
                    w_in_nxt    = state_in;
                    w_enc_nxt   = enc;
`ifdef XC_AESMIX_SEQ_ARK_EN
                    w_key_nxt   = key_in;
`endif
                    w_col_nxt   = 2'd0;
                    w_state_nxt = ST_FLUSH;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_FLUSH: begin
                if (abort) begin
                    w_state_nxt = ST_ABORT;
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // abort wins over a same-cycle ready; that result is dropped
                if (abort) begin
                    w_state_nxt = ST_ABORT;
                end else if (mix.mix_ready) begin
                    w_buf_nxt = put_word(r_buf, r_col, w_cap_word);
                    if (r_col == 2'd3) begin
                        // publish the complete buffer, including the column
                        // captured on this very edge
                        w_out_nxt   = w_buf_nxt;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_col_nxt   = r_col + 2'd1;
                    end
                end else begin
                    w_state_nxt = ST_ISSUE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            ST_ABORT: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State registers; outputs are decoded from the next state so they are
    // registered and never combinationally depend on mix_ready.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_col       <= 2'd0;
            r_in        <= 128'h0;
            r_enc       <= 1'b0;
            r_buf       <= 128'h0;
            r_state_out <= 128'h0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mix_valid <= 1'b0;
            r_mix_flush <= 1'b0;
            r_mix_enc   <= 1'b0;
            r_mix_op    <= 32'h0;
`ifdef XC_AESMIX_SEQ_ARK_EN
            r_key       <= 128'h0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_col       <= w_col_nxt;
            r_in        <= w_in_nxt;
            r_enc       <= w_enc_nxt;
            r_buf       <= w_buf_nxt;
            r_state_out <= w_out_nxt;
            r_busy      <= (w_state_nxt != ST_IDLE);
            r_done      <= (w_state_nxt == ST_DONE);
            r_mix_valid <= (w_state_nxt == ST_ISSUE);
            r_mix_flush <= (w_state_nxt == ST_FLUSH) || (w_state_nxt == ST_ABORT);
            r_mix_enc   <= w_enc_nxt;
            r_mix_op    <= col_word(w_in_nxt, w_col_nxt);
`ifdef XC_AESMIX_SEQ_ARK_EN
            r_key       <= w_key_nxt;
`endif
        end
    end

    assign busy               = r_busy;
    assign done               = r_done;
    assign state_out          = r_state_out;
    assign mix.mix_flush      = r_mix_flush;
    assign mix.mix_flush_data = 32'h0000_0000;
    assign mix.mix_valid      = r_mix_valid;
    assign mix.mix_enc        = r_mix_enc;
    assign mix.mix_rs1        = r_mix_op;
    assign mix.mix_rs2        = r_mix_op;

endmodule

// File: tb/tb_xc_aesmix_seq.sv
// ---------------------------------------------------------------------------
// tb_xc_aesmix_seq
// Bench for xc_aesmix_seq. A behavioural xc_aesmix unit (latency 1 or 4,
// switchable between operations) answers the sequencer. Expected states are
// computed with GF(2^8) matrix arithmetic and queued at start time; a
// separate monitor pops and compares on every done pulse.
// ---------------------------------------------------------------------------
module tb_xc_aesmix_seq;

    logic         clock;
    logic         reset;
    logic         start;
    logic         abort;
    logic         enc;
    logic [127:0] state_in;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic [127:0] state_out;

    xc_aesmix_seq_if mix_if ();

    xc_aesmix_seq dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .abort     (abort),
        .enc       (enc),
        .state_in  (state_in),
        .key_in    (key_in),
        .busy      (busy),
        .done      (done),
        .state_out (state_out),
        .mix       (mix_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;
    int unsigned cyc = 0;
    int lat = 1;

    typedef struct {
        logic [127:0] st;
        int unsigned  cyc;
    } exp_t;
    exp_t q[$];

    logic [127:0] cur_in  = 128'h0;
    logic         cur_enc = 1'b0;
    logic [127:0] last_exp = 128'h0;

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p = 8'h00;
        aa = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p = p ^ aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] w, input logic e);
        logic [7:0]  a [4];
        logic [7:0]  c [4];
        logic [31:0] r;
        for (int j = 0; j < 4; j++) a[j] = w[8*j +: 8];
        if (e) c = '{8'd2, 8'd3, 8'd1, 8'd1};
        else   c = '{8'd14, 8'd11, 8'd13, 8'd9};
        r = 32'h0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                r[8*i +: 8] = r[8*i +: 8] ^ gmul(c[(j - i + 4) % 4], a[j]);
        return r;
    endfunction

    function automatic logic [127:0] model(input logic [127:0] s, input logic e,
                                           input logic [127:0] k);
        logic [127:0] r;
        for (int c = 0; c < 4; c++) begin
            r[32*c +: 32] = mixcol(s[32*c +: 32], e);
`ifdef XC_AESMIX_SEQ_ARK_EN
            r[32*c +: 32] = r[32*c +: 32] ^ k[32*c +: 32];
`else
            if (k === 128'hx) r[32*c +: 32] = 32'h0;
`endif
        end
        return r;
    endfunction

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, expv);
        end
    endtask

    // ---------------- behavioural xc_aesmix unit ----------------
    int         u_cnt = 0;
    logic [1:0] exp_col = 2'd0;

    assign mix_if.mix_ready  = mix_if.mix_valid && (u_cnt == lat - 1);
    assign mix_if.mix_result = mixcol(mix_if.mix_rs1, mix_if.mix_enc);

    always @(posedge clock) begin
        cyc <= cyc + 1;
        if (reset || mix_if.mix_flush) begin
            u_cnt   <= 0;
            exp_col <= 2'd0;
        end else if (mix_if.mix_valid) begin
            if (mix_if.mix_ready) begin
                u_cnt   <= 0;
                exp_col <= exp_col + 2'd1;
            end else begin
                u_cnt <= u_cnt + 1;
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clock) begin
        if (!reset) begin
            if (mix_if.mix_valid) begin
                chk("operand_rs1", mix_if.mix_rs1, cur_in[32*exp_col +: 32]);
                chk("operand_rs2", mix_if.mix_rs2, cur_in[32*exp_col +: 32]);
                chk("operand_enc", mix_if.mix_enc, cur_enc);
            end
            if (done) begin
                if (q.size() == 0) begin
                    chk("spurious_done", 1'b1, 1'b0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("state_out", state_out, e.st);
                    chk("done_cycle", cyc, e.cyc);
                    last_exp = e.st;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    // mode: 0 normal, 1 start pulsed while busy, 2 abort at column 2,
    //       3 reset while issuing
    task automatic op(input logic [127:0] s, input logic e, input logic [127:0] k,
                      input logic [127:0] expv, input int mode);
        int  nv;
        bit  got;
        int unsigned t0;
        @(negedge clock);
        start = 1'b1; enc = e; state_in = s; key_in = k;
        cur_in = s; cur_enc = e; t0 = cyc;
        if (mode < 2) q.push_back('{expv, t0 + 2 + 4 * lat});
        @(negedge clock);
        start = 1'b0; enc = ~e;
        state_in = {$urandom, $urandom, $urandom, $urandom};
        key_in   = {$urandom, $urandom, $urandom, $urandom};
        chk("flush_cycle", {mix_if.mix_flush, mix_if.mix_valid, busy, mix_if.mix_flush_data},
            {1'b1, 1'b0, 1'b1, 32'h0});
        nv = 0;
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            start = (mode == 1 && i == 1);
            if (start) state_in = {$urandom, $urandom, $urandom, $urandom};
            if (mode == 2 && i == 2 * lat) begin
                abort = 1'b1;
                @(negedge clock);
                abort = 1'b0;
                chk("abort_cycle", {mix_if.mix_flush, mix_if.mix_valid, busy, done}, 4'b1010);
                @(negedge clock);
                chk("abort_idle", {busy, mix_if.mix_flush, done}, 3'b000);
                chk("abort_hold", state_out, last_exp);
                got = 1'b1;
            end else if (mode == 3 && i == 1) begin
                reset = 1'b1;
                @(negedge clock);
                chk("mid_reset_ctl", {busy, done, mix_if.mix_valid, mix_if.mix_flush,
                    mix_if.mix_enc}, 5'b0);
                chk("mid_reset_out", state_out, 128'h0);
                chk("mid_reset_ops", {mix_if.mix_rs1, mix_if.mix_rs2, mix_if.mix_flush_data},
                    96'h0);
                reset = 1'b0;
                last_exp = 128'h0;
                got = 1'b1;
            end else if (done) begin
                got = 1'b1;
            end else if (mix_if.mix_valid) begin
                nv++;
            end
        end
        if (!got) chk("done_timeout", 1'b0, 1'b1);
        else if (mode < 2) chk("valid_cycles", nv, 4 * lat);
    endtask

    localparam logic [127:0] V1 = 128'h01010101_c6c6c6c6_5c220af2_455313db;
    localparam logic [127:0] E1 = 128'h01010101_c6c6c6c6_9d58dc9f_bca14d8e;
    localparam logic [127:0] ONES = {128{1'b1}};

    initial begin
        logic [127:0] s;
        logic [127:0] k;
        logic         e;
        reset = 1'b1; start = 1'b0; abort = 1'b0; enc = 1'b0;
        state_in = 128'h0; key_in = 128'h0;
        repeat (3) @(negedge clock);
        chk("reset_ctl", {busy, done, mix_if.mix_valid, mix_if.mix_flush, mix_if.mix_enc}, 5'b0);
        chk("reset_out", state_out, 128'h0);
        chk("reset_ops", {mix_if.mix_rs1, mix_if.mix_rs2, mix_if.mix_flush_data}, 96'h0);
        reset = 1'b0;

        // single-cycle unit: forward and inverse vectors
        lat = 1;
        op(V1, 1'b1, 128'h0, E1, 0);
        op(E1, 1'b0, 128'h0, V1, 0);
`ifdef XC_AESMIX_SEQ_ARK_EN
        op(V1, 1'b1, ONES, E1 ^ ONES, 0);
`endif
        // multi-cycle unit
        lat = 4;
        op(V1, 1'b1, 128'h0, E1, 0);
        op(E1, 1'b0, 128'h0, V1, 0);

        // abort during column 2, then a fresh operation
        op(V1, 1'b1, 128'h0, 128'h0, 2);
        op({4{32'hd5d4d4d4}}, 1'b1, 128'h0, {4{32'hd6d7d5d5}}, 0);
        lat = 1;
        op(E1, 1'b0, 128'h0, 128'h0, 2);
        op(V1, 1'b1, 128'h0, E1, 1);

        // start together with abort in IDLE stays idle
        @(negedge clock);
        start = 1'b1; abort = 1'b1; state_in = V1;
        @(negedge clock);
        start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {busy, mix_if.mix_flush, mix_if.mix_valid}, 3'b000);

        // reset while issuing
        lat = 4;
        op(V1, 1'b1, 128'h0, 128'h0, 3);

        // randomized operations
        for (int n = 0; n < 16; n++) begin
            lat = ($urandom_range(0, 1) == 0) ? 1 : 4;
            s = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
            e = 1'($urandom_range(0, 1));
            op(s, e, k, model(s, e, k), (n % 5 == 4) ? 1 : 0);
        end

        repeat (3) @(negedge clock);
        chk("queue_empty", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
